seg_scan_ctrl: RTL and testbench

//  Parametrised N-digit 7-segment scan driver, next generation of the fixed 8-digit display controller.

---
 rtl/seg_scan_ctrl_pkg.sv | 35 +++
 rtl/seg_scan_ctrl_if.sv | 14 +
 rtl/seg_scan_ctrl_bin2bcd_seq.sv | 61 ++++++
 rtl/seg_scan_ctrl.sv | 70 +++++++
 tb/tb_seg_scan_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// seg_scan_ctrl_pkg: segment glyphs, converter states and helpers shared by the seg_scan_ctrl slice
package seg_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;
  localparam logic [7:0] SEG_0 = 8'b00000011;
  localparam logic [7:0] SEG_1 = 8'b10011111;
  localparam logic [7:0] SEG_2 = 8'b00100101;
  localparam logic [7:0] SEG_3 = 8'b00001101;
  localparam logic [7:0] SEG_4 = 8'b10011001;
  localparam logic [7:0] SEG_5 = 8'b01001001;
  localparam logic [7:0] SEG_6 = 8'b01000001;
  localparam logic [7:0] SEG_7 = 8'b00011111;
  localparam logic [7:0] SEG_8 = 8'b00000001;
  localparam logic [7:0] SEG_9 = 8'b00011001;
  localparam logic [7:0] SEG_DASH = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: bcd_to_seg = SEG_0;
      4'd1: bcd_to_seg = SEG_1;
      4'd2: bcd_to_seg = SEG_2;
      4'd3: bcd_to_seg = SEG_3;
      4'd4: bcd_to_seg = SEG_4;
      4'd5: bcd_to_seg = SEG_5;
      4'd6: bcd_to_seg = SEG_6;
      4'd7: bcd_to_seg = SEG_7;
      4'd8: bcd_to_seg = SEG_8;
      4'd9: bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction
  function automatic int unsigned pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: application-side load/display bus of seg_scan_ctrl
//   load, value, dp_in, blank : driven by the application (master)
//   busy, an, seg             : driven by the scan controller (slave)
interface seg_scan_ctrl_if #(parameter int N_DIG = 8, parameter int BIN_W = 27);
  logic load;
  logic [BIN_W-1:0] value;
  logic [N_DIG-1:0] dp_in;
  logic blank;
  logic busy;
  logic [N_DIG-1:0] an;
  logic [7:0] seg;
  modport master(output load, value, dp_in, blank, input busy, an, seg);
  modport slave(input load, value, dp_in, blank, output busy, an, seg);
endinterface

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift/add-3 step per cycle
//   clk, rst_n (async, active-low); load_i/value_i start a conversion when idle
//   busy_o high outside IDLE; done_o pulses for one cycle with bcd_o/ovf_o valid
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIG = 8,
  parameter int BIN_W = 27
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [BIN_W-1:0]       value_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*N_DIG-1:0]     bcd_o,
  output logic                   ovf_o
);
  localparam int CW = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAX_V = BIN_W'(pow10(N_DIG) - 1);
  conv_state_t state_q;
  logic [BIN_W-1:0] sr_q;
  logic [4*N_DIG-1:0] bcd_q, adj_d;
  logic [CW-1:0] cnt_q;
  logic ovf_q;
  always_comb begin
    adj_d = bcd_q;
    for (int k = 0; k < N_DIG; k++)
      adj_d[4*k+:4] = bcd_q[4*k+:4] > 4'd4 ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
  end
  // overflow is decided from the captured value; the N_DIG-digit register only has to be exact below it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load_i) begin
          state_q <= CONV;
          sr_q <= value_i;
          bcd_q <= '0;
          cnt_q <= '0;
          ovf_q <= value_i > MAX_V;
        end
        CONV: begin
          bcd_q <= {adj_d[4*N_DIG-2:0], sr_q[BIN_W-1]};
          sr_q <= sr_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(BIN_W - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign bcd_o = bcd_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed 7-segment driver with sequential binary-to-BCD load path
//   clk, rst_n (async, active-low); bus (seg_scan_ctrl_if.slave): load/value/dp_in/blank in,
//   busy/an/seg out (an and seg active-low). Define SEG_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIG = 8,
  parameter int BIN_W = 27,
  parameter int SCAN_DIV = 20000
) (
  input logic clk,
  input logic rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  logic [SW-1:0] cnt_q;
  logic [N_DIG-1:0] an_q, show;
  logic [4*N_DIG-1:0] buf_q, bcd;
  logic ovf_q, ovf, done, dp_n;
  logic [7:0] glyph;
  bin2bcd_seq #(.N_DIG(N_DIG), .BIN_W(BIN_W)) u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(bus.load),
    .value_i(bus.value),
    .busy_o(bus.busy),
    .done_o(done),
    .bcd_o(bcd),
    .ovf_o(ovf)
  );
  // buffer only changes on done, so the display swaps whole values
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= SW'(1);
      an_q <= ~(N_DIG'(1) << (N_DIG - 1));
      buf_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q == SW'(SCAN_DIV) ? SW'(1) : cnt_q + 1'b1;
      if (cnt_q == SW'(SCAN_DIV)) an_q <= {an_q[0], an_q[N_DIG-1:1]};
      if (done) begin
        buf_q <= bcd;
        ovf_q <= ovf;
      end
    end
`ifdef SEG_LZB_EN
  logic nz;
  always_comb begin
    nz = 1'b0;
    show = '0;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      nz = nz | (buf_q[4*k+:4] != 4'd0);
      show[k] = nz | (k == 0);
    end
  end
`else
  assign show = '1;
`endif
  always_comb begin
    glyph = SEG_BLANK;
    dp_n = 1'b1;
    for (int k = 0; k < N_DIG; k++)
      if (!an_q[k]) begin
        glyph = ovf_q ? SEG_DASH : show[k] ? bcd_to_seg(buf_q[4*k+:4]) : SEG_BLANK;
        dp_n = ~bus.dp_in[k];
      end
  end
  assign bus.an = bus.blank ? '1 : an_q;
  assign bus.seg = bus.blank ? SEG_BLANK : {glyph[7:1], dp_n};
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench for seg_scan_ctrl against a decimal-arithmetic model
module tb_seg_scan_ctrl;
  localparam int N = 4, W = 14, D = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  seg_scan_ctrl_if #(.N_DIG(N), .BIN_W(W)) bus ();
  seg_scan_ctrl #(.N_DIG(N), .BIN_W(W), .SCAN_DIV(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0, n_pass = 0;
  int t = 0, busy_cnt = 0, disp = 0, pend = 0;
  logic [7:0] glyph_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                                 8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00011001};
  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  function automatic logic [7:0] exp_seg(input int v, input int sel, input logic [N-1:0] dp, input logic bl);
    logic [7:0] g;
    if (bl) return 8'hFF;
    if (v > p10(N) - 1) g = 8'b11111101;
    else begin
      g = glyph_tab[(v / p10(sel)) % 10];
`ifdef SEG_LZB_EN
      if (sel != 0 && v < p10(sel)) g = 8'hFF;
`endif
    end
    return {g[7:1], ~dp[sel]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // model: value appears BIN_W+1 edges after an accepted load; scan slot advances every D edges
  initial forever begin
    bit pre;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t = 0;
      busy_cnt = 0;
      disp = 0;
      pend = 0;
    end else begin
      pre = busy_cnt > 0;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) disp = pend;
      end
      if (bus.load && !pre) begin
        pend = int'(bus.value);
        busy_cnt = W + 1;
      end
      t++;
    end
  end
  initial forever begin
    int sel;
    logic [3:0] ea;
    @(posedge clk);
    #1;
    sel = N - 1 - ((t / D) % N);
    ea = bus.blank ? 4'hF : ~(4'b1 << sel);
    chk("model_busy", {31'd0, bus.busy}, {31'd0, busy_cnt > 0});
    chk("model_an", {28'd0, bus.an}, {28'd0, ea});
    chk("model_seg", {24'd0, bus.seg}, {24'd0, exp_seg(disp, sel, bus.dp_in, bus.blank)});
  end
  task automatic run_load(input int v, input int inj_at, input int v2, output int len);
    len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.load = (i == 0) || (i == inj_at);
      bus.value = i == 0 ? v[W-1:0] : v2[W-1:0];
      @(posedge clk);
      #1;
      if (bus.busy) len++;
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic grab(output logic [31:0] s);
    s = '0;
    for (int i = 0; i < 2 * N * D; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (!bus.an[k]) s[8*k+:8] = bus.seg;
    end
  endtask
  initial begin
    int len;
    logic [31:0] s;
    bus.load = 1'b0;
    bus.value = '0;
    bus.dp_in = '0;
    bus.blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {28'd0, bus.an}, 32'b0111);
`ifndef SEG_LZB_EN
    chk("rst_seg", {24'd0, bus.seg}, 32'b00000011);
`endif
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_rot_after_3", {28'd0, bus.an}, 32'b0111);
    @(posedge clk);
    #1;
    chk("rot_after_4", {28'd0, bus.an}, 32'b1011);
    run_load(1234, -1, 0, len);
    chk("busy_len_1234", len, 15);
    grab(s);
    chk("d3_1234", {24'd0, s[31:24]}, 32'b10011111);
    chk("d2_1234", {24'd0, s[23:16]}, 32'b00100101);
    chk("d1_1234", {24'd0, s[15:8]}, 32'b00001101);
    chk("d0_1234", {24'd0, s[7:0]}, 32'b10011001);
    run_load(10000, -1, 0, len);
    grab(s);
    for (int k = 0; k < N; k++) chk("ovf_dash", {24'd0, s[8*k+:8]}, 32'b11111101);
    @(negedge clk);
    bus.dp_in = 4'b0001;
    grab(s);
    chk("ovf_dp_d0", {24'd0, s[7:0]}, 32'b11111100);
    chk("ovf_dp_d1", {24'd0, s[15:8]}, 32'b11111101);
    @(negedge clk);
    bus.dp_in = '0;
    run_load(42, 5, 999, len);
    chk("busy_len_inject", len, 15);
    grab(s);
    chk("inject_d0", {24'd0, s[7:0]}, 32'b00100101);
    chk("inject_d1", {24'd0, s[15:8]}, 32'b10011001);
    run_load(815, 15, 3, len);
    chk("busy_len_done_inject", len, 15);
    grab(s);
    chk("done_inject_d0", {24'd0, s[7:0]}, 32'b01001001);
    @(negedge clk);
    bus.blank = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("blank_an", {28'd0, bus.an}, 32'hF);
    chk("blank_seg", {24'd0, bus.seg}, 32'hFF);
    @(negedge clk);
    bus.blank = 1'b0;
`ifdef SEG_LZB_EN
    run_load(7, -1, 0, len);
    grab(s);
    chk("lzb7_d3", {24'd0, s[31:24]}, 32'hFF);
    chk("lzb7_d2", {24'd0, s[23:16]}, 32'hFF);
    chk("lzb7_d1", {24'd0, s[15:8]}, 32'hFF);
    chk("lzb7_d0", {24'd0, s[7:0]}, 32'b00011111);
    run_load(0, -1, 0, len);
    grab(s);
    chk("lzb0_d1", {24'd0, s[15:8]}, 32'hFF);
    chk("lzb0_d0", {24'd0, s[7:0]}, 32'b00000011);
`endif
    @(negedge clk);
    bus.load = 1'b1;
    bus.value = 14'd3210;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midconv_busy", {31'd0, bus.busy}, 32'd0);
    chk("midconv_an", {28'd0, bus.an}, 32'b0111);
    @(negedge clk);
    rst_n = 1'b1;
    run_load(56, -1, 0, len);
    chk("busy_len_after_rst", len, 15);
    grab(s);
    chk("after_rst_d1", {24'd0, s[15:8]}, 32'b01001001);
    chk("after_rst_d0", {24'd0, s[7:0]}, 32'b01000001);
    for (int r = 0; r < 60; r++) begin
      repeat ($urandom_range(0, 20)) begin
        @(negedge clk);
        bus.load = 1'b0;
        bus.dp_in = 4'($urandom);
        bus.blank = $urandom_range(0, 7) == 0;
      end
      @(negedge clk);
      bus.load = 1'b1;
      case ($urandom_range(0, 3))
        0: bus.value = 14'($urandom_range(0, 9));
        1: bus.value = 14'($urandom_range(0, 9999));
        2: bus.value = 14'($urandom_range(9990, 10010));
        default: bus.value = 14'($urandom_range(0, 16383));
      endcase
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.blank = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
